// File: rtl/alu_sched_pkg.sv
// Shared op codes, flag bit positions and scheduler state type for alu_sched.
package alu_pkg;

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam int FLG_NEG   = 3;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_OVF   = 1;
  localparam int FLG_CARRY = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return op == OP_ILL;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response handshakes of both ports plus the shared-ALU connection.
// slave = scheduler side, master = requesters and ALU side.
interface alu_sched_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_cntrl0;
  logic [2:0]       req_cntrl1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_cntrl0, req_cntrl1,
    input  alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cntrl, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_cntrl0, req_cntrl1,
    output alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cntrl, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (i_en && (i_req != 2'b00)) begin
      r_last <= o_grant[1];
    end
  end
endmodule

// File: rtl/alu_sched.sv
// Time-shares one combinational ALU between two requesters, one op in flight.
// Optional statistics counters are built when ALU_SCHED_STATS_EN is defined.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_sched_if.slave bus
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic [1:0]       w_grant;
  logic             w_grant_en;
  logic [1:0]       w_req_ready;
  logic             w_gnt_id;
  logic [2:0]       w_req_op;
  logic [WIDTH-1:0] w_req_a;
  logic [WIDTH-1:0] w_req_b;
  logic             r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_cntrl;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (bus.req_valid),
    .i_en    (w_grant_en),
    .o_grant (w_grant)
  );

  assign w_gnt_id = w_grant[1];
  assign w_req_op = w_gnt_id ? bus.req_cntrl1 : bus.req_cntrl0;
  assign w_req_a  = w_gnt_id ? bus.req_a1 : bus.req_a0;
  assign w_req_b  = w_gnt_id ? bus.req_b1 : bus.req_b0;

  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_req_ready  = 2'b00;
    case (r_state)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          w_grant_en   = 1'b1;
          w_req_ready  = w_grant;
          w_state_next = EXEC;
        end
      end
      EXEC: w_state_next = RESP;
      RESP: begin
        if (bus.rsp_ready[r_id]) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The ALU operand registers double as the holding registers; an illegal op
  // leaves them untouched so the ALU never sees new values for it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_id         <= 1'b0;
      r_op         <= OP_PASSB;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cntrl  <= OP_PASSB;
      r_rsp_result <= '0;
      r_rsp_flags  <= 4'b0000;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_en) begin
        r_id <= w_gnt_id;
        r_op <= w_req_op;
        if (!is_illegal(w_req_op)) begin
          r_alu_a     <= w_req_a;
          r_alu_b     <= w_req_b;
          r_alu_cntrl <= w_req_op;
        end
      end
      if (r_state == EXEC) begin
        if (is_illegal(r_op)) begin
          r_rsp_result <= '0;
          r_rsp_flags  <= 4'b0000;
          r_rsp_err    <= 1'b1;
        end else begin
          r_rsp_result <= bus.alu_result;
          r_rsp_flags  <= bus.alu_flags;
          r_rsp_err    <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_cntrl  = r_alu_cntrl;
  assign bus.rsp_valid  = (r_state == RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_err    = r_rsp_err;

`ifdef ALU_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_grant_cnt0;
  logic [CNT_W-1:0] r_grant_cnt1;
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_grant_en && !w_gnt_id && (r_grant_cnt0 != '1)) begin
        r_grant_cnt0 <= r_grant_cnt0 + CNT_ONE;
      end
      if (w_grant_en && w_gnt_id && (r_grant_cnt1 != '1)) begin
        r_grant_cnt1 <= r_grant_cnt1 + CNT_ONE;
      end
      if ((r_state == EXEC) && is_illegal(r_op) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign err_cnt    = r_err_cnt;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: behavioural ALU, arbitration and counter model.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int WIDTH    = 64;
  localparam int TB_CNT_W = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: last granted port and per-kind event counts since reset.
  logic m_last = 1'b1;
  int   m_g0   = 0;
  int   m_g1   = 0;
  int   m_err  = 0;

  alu_sched_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_SCHED_STATS_EN
  logic [TB_CNT_W-1:0] grant_cnt0;
  logic [TB_CNT_W-1:0] grant_cnt1;
  logic [TB_CNT_W-1:0] err_cnt;
`endif

  alu_sched #(.WIDTH(WIDTH), .CNT_W(TB_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_SCHED_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags, result}.
  function automatic logic [67:0] alu_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        c;
    logic        v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0]; c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = b;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  // Expected response: {err, flags, result}.
  function automatic logic [68:0] rsp_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == OP_ILL) return {1'b1, 68'd0};
    return {1'b0, alu_ref(op, a, b)};
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic int sat(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always_comb begin
    {bus.alu_flags, bus.alu_result} = alu_ref(bus.alu_cntrl, bus.alu_a, bus.alu_b);
  end

  // Drives one request, waits (bounded) for grant and response; returns observations.
  task automatic run_op(input logic [1:0] v,
                        input logic [2:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                        input logic [2:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                        output logic [1:0] gnt, output int lat, output logic [1:0] rv,
                        output logic [68:0] rsp);
    gnt = 2'b00; lat = -1; rv = 2'b00; rsp = '0;
    @(posedge clk); #1;
    bus.req_cntrl0 = op0; bus.req_a0 = a0; bus.req_b0 = b0;
    bus.req_cntrl1 = op1; bus.req_a1 = a1; bus.req_b1 = b1;
    bus.req_valid  = v;
    bus.rsp_ready  = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        gnt = bus.req_ready;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (gnt != 2'b00) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (bus.rsp_valid != 2'b00) begin
          lat = i;
          rv  = bus.rsp_valid;
          rsp = {bus.rsp_err, bus.rsp_flags, bus.rsp_result};
          break;
        end
      end
    end
    $display("txn: valid=%b grant=%b latency=%0d err=%b flags=%b result=%h",
             v, gnt, lat, rsp[68], rsp[67:64], rsp[63:0]);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, expected 00 00", bus.req_ready, bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_result !== 64'd0 || bus.rsp_flags !== 4'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: result=%h flags=%b err=%b, expected all zero", bus.rsp_result, bus.rsp_flags, bus.rsp_err);
    end
    n_checks++;
    if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0 || bus.alu_cntrl !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h cntrl=%b, expected all zero", bus.alu_a, bus.alu_b, bus.alu_cntrl);
    end
`ifdef ALU_SCHED_STATS_EN
    n_checks++;
    if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || err_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: g0=%0d g1=%0d err=%0d, expected 0 0 0", grant_cnt0, grant_cnt1, err_cnt);
    end
`endif
    m_last = 1'b1; m_g0 = 0; m_g1 = 0; m_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_add();
    logic [1:0]  gnt;
    logic [1:0]  rv;
    int          lat;
    logic [68:0] rsp;
    run_op(2'b01, OP_ADD, 64'd5, 64'd7, OP_PASSB, 64'd0, 64'd0, gnt, lat, rv, rsp);
    m_last = 1'b0; m_g0++;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL add_grant: req_ready=%b, expected 01", gnt);
    end
    n_checks++;
    if (lat != 2 || rv !== 2'b01) begin
      n_fail++;
      $display("FAIL add_latency: latency=%0d rsp_valid=%b, expected 2 01", lat, rv);
    end
    n_checks++;
    if (rsp[63:0] !== 64'd12 || rsp[64+FLG_ZERO] !== 1'b0 || rsp !== rsp_ref(OP_ADD, 64'd5, 64'd7)) begin
      n_fail++;
      $display("FAIL add_result: result=%h flags=%b err=%b, expected 12 flags=%b err=0",
               rsp[63:0], rsp[67:64], rsp[68], 4'b0000);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  gnt;
    logic [1:0]  rv;
    int          lat;
    logic [68:0] rsp;
    logic [63:0] old_a;
    logic [63:0] old_b;
    logic [2:0]  old_c;
    @(negedge clk);
    old_a = bus.alu_a; old_b = bus.alu_b; old_c = bus.alu_cntrl;
    run_op(2'b10, OP_ADD, rnd64(), rnd64(), OP_ILL, rnd64(), rnd64(), gnt, lat, rv, rsp);
    m_last = 1'b1; m_g1++; m_err++;
    n_checks++;
    if (gnt !== 2'b10 || lat != 2 || rv !== 2'b10) begin
      n_fail++;
      $display("FAIL ill_handshake: grant=%b latency=%0d rsp_valid=%b, expected 10 2 10", gnt, lat, rv);
    end
    n_checks++;
    if (rsp !== {1'b1, 68'd0}) begin
      n_fail++;
      $display("FAIL ill_rsp: err=%b flags=%b result=%h, expected err=1 flags=0 result=0", rsp[68], rsp[67:64], rsp[63:0]);
    end
    n_checks++;
    if (bus.alu_a !== old_a || bus.alu_b !== old_b || bus.alu_cntrl !== old_c) begin
      n_fail++;
      $display("FAIL ill_alu_hold: a=%h b=%h cntrl=%b, expected a=%h b=%h cntrl=%b",
               bus.alu_a, bus.alu_b, bus.alu_cntrl, old_a, old_b, old_c);
    end
`ifdef ALU_SCHED_STATS_EN
    n_checks++;
    if (err_cnt !== TB_CNT_W'(1)) begin
      n_fail++;
      $display("FAIL ill_err_cnt: err_cnt=%0d, expected 1", err_cnt);
    end
`endif
  endtask

  task automatic test_contention();
    logic [1:0]  eg;
    logic        pend_id;
    logic [68:0] pend_exp;
    int          cyc;
    int          grants;
    int          resps;
    int          last_g_cyc;
    pend_id = 1'b0; pend_exp = '0;
    cyc = 0; grants = 0; resps = 0; last_g_cyc = 0;
    @(posedge clk); #1;
    bus.rsp_ready  = 2'b11;
    bus.req_cntrl0 = OP_SUB; bus.req_a0 = 64'h3;  bus.req_b0 = 64'h3;
    bus.req_cntrl1 = OP_XOR; bus.req_a1 = 64'hF0; bus.req_b1 = 64'h0F;
    bus.req_valid  = 2'b11;
    while (resps < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid != 2'b00) begin
        resps++;
        n_checks++;
        if (bus.rsp_valid !== (pend_id ? 2'b10 : 2'b01) ||
            {bus.rsp_err, bus.rsp_flags, bus.rsp_result} !== pend_exp || bus.req_ready !== 2'b00) begin
          n_fail++;
          $display("FAIL cont_rsp: valid=%b ready=%b err=%b flags=%b result=%h, expected valid=%b ready=00 err=%b flags=%b result=%h",
                   bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_flags, bus.rsp_result,
                   pend_id ? 2'b10 : 2'b01, pend_exp[68], pend_exp[67:64], pend_exp[63:0]);
        end
        $display("txn: contention port=%0d err=%b flags=%b result=%h", pend_id, bus.rsp_err, bus.rsp_flags, bus.rsp_result);
      end else if (bus.req_ready != 2'b00) begin
        eg = exp_grant(bus.req_valid);
        n_checks++;
        if (bus.req_ready !== eg || (grants > 0 && (cyc - last_g_cyc) != 3)) begin
          n_fail++;
          $display("FAIL cont_grant: grant=%b spacing=%0d, expected grant=%b spacing=3", bus.req_ready, cyc - last_g_cyc, eg);
        end
        pend_id  = (eg == 2'b10);
        pend_exp = pend_id ? rsp_ref(bus.req_cntrl1, bus.req_a1, bus.req_b1)
                           : rsp_ref(bus.req_cntrl0, bus.req_a0, bus.req_b0);
        m_last = pend_id;
        if (pend_id) m_g1++; else m_g0++;
        grants++;
        last_g_cyc = cyc;
        @(posedge clk); #1;
        if (grants == 8) begin
          bus.req_valid = 2'b00;
        end else if (grants >= 4) begin
          if (pend_id) begin
            bus.req_cntrl1 = 3'($urandom_range(0, 6)); bus.req_a1 = rnd64(); bus.req_b1 = rnd64();
          end else begin
            bus.req_cntrl0 = 3'($urandom_range(0, 6)); bus.req_a0 = rnd64(); bus.req_b0 = rnd64();
          end
        end
      end
    end
    bus.req_valid = 2'b00;
    n_checks++;
    if (resps != 8) begin
      n_fail++;
      $display("FAIL cont_count: responses=%0d, expected 8", resps);
    end
  endtask

  task automatic test_backpressure();
    logic [68:0] exp0;
    logic [68:0] exp1;
    logic        got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_cntrl0 = 3'($urandom_range(0, 6)); bus.req_a0 = rnd64(); bus.req_b0 = rnd64();
    bus.req_cntrl1 = OP_OR; bus.req_a1 = rnd64(); bus.req_b1 = rnd64();
    exp0 = rsp_ref(bus.req_cntrl0, bus.req_a0, bus.req_b0);
    exp1 = rsp_ref(OP_OR, bus.req_a1, bus.req_b1);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready != 2'b00);
    end
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: req_ready=%b, expected 01", bus.req_ready);
    end
    m_last = 1'b0; m_g0++;
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00 ||
          {bus.rsp_err, bus.rsp_flags, bus.rsp_result} !== exp0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid=%b ready=%b err=%b flags=%b result=%h, expected valid=01 ready=00 err=%b flags=%b result=%h",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_flags, bus.rsp_result,
                 exp0[68], exp0[67:64], exp0[63:0]);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_handshake: valid=%b ready=%b, expected 01 00", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_idle: valid=%b ready=%b, expected 00 10", bus.rsp_valid, bus.req_ready);
    end
    m_last = 1'b1; m_g1++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.rsp_valid != 2'b00);
    end
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || {bus.rsp_err, bus.rsp_flags, bus.rsp_result} !== exp1) begin
      n_fail++;
      $display("FAIL bp_port1: valid=%b result=%h, expected valid=10 result=%h", bus.rsp_valid, bus.rsp_result, exp1[63:0]);
    end
    $display("txn: backpressure port0 result=%h port1 result=%h", exp0[63:0], bus.rsp_result);
  endtask

  task automatic test_stats();
`ifdef ALU_SCHED_STATS_EN
    logic [1:0]  gnt;
    logic [1:0]  rv;
    int          lat;
    logic [68:0] rsp;
    for (int i = 0; i < 5; i++) begin
      run_op(2'b01, OP_ADD, rnd64(), rnd64(), OP_PASSB, 64'd0, 64'd0, gnt, lat, rv, rsp);
      if (gnt == 2'b01) begin
        m_last = 1'b0; m_g0++;
      end
    end
    n_checks++;
    if (grant_cnt0 !== TB_CNT_W'(sat(m_g0)) || grant_cnt0 !== 2'b11) begin
      n_fail++;
      $display("FAIL stats_sat: grant_cnt0=%0d, expected %0d", grant_cnt0, sat(m_g0));
    end
    n_checks++;
    if (grant_cnt1 !== TB_CNT_W'(sat(m_g1)) || err_cnt !== TB_CNT_W'(sat(m_err))) begin
      n_fail++;
      $display("FAIL stats_other: grant_cnt1=%0d err_cnt=%0d, expected %0d %0d", grant_cnt1, err_cnt, sat(m_g1), sat(m_err));
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0]  gnt;
    logic [1:0]  rv;
    int          lat;
    logic [68:0] rsp;
    logic [63:0] a0;
    logic [63:0] b0;
    logic        got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_cntrl0 = OP_ADD; bus.req_a0 = rnd64(); bus.req_b0 = rnd64();
    bus.req_valid  = 2'b01;
    bus.rsp_ready  = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready != 2'b00);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 64'd0 ||
        bus.rsp_flags !== 4'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rsp: ready=%b valid=%b result=%h flags=%b err=%b, expected all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_err);
    end
    n_checks++;
    if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0 || bus.alu_cntrl !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_alu: a=%h b=%h cntrl=%b, expected all zero", bus.alu_a, bus.alu_b, bus.alu_cntrl);
    end
`ifdef ALU_SCHED_STATS_EN
    n_checks++;
    if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || err_cnt !== '0) begin
      n_fail++;
      $display("FAIL rstmid_stats: g0=%0d g1=%0d err=%0d, expected 0 0 0", grant_cnt0, grant_cnt1, err_cnt);
    end
`endif
    m_last = 1'b1; m_g0 = 0; m_g1 = 0; m_err = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_norsp: rsp_valid=%b, expected 00", bus.rsp_valid);
    end
    a0 = rnd64(); b0 = rnd64();
    run_op(2'b11, OP_SUB, a0, b0, OP_AND, rnd64(), rnd64(), gnt, lat, rv, rsp);
    m_last = 1'b0; m_g0++;
    n_checks++;
    if (gnt !== 2'b01 || rv !== 2'b01 || rsp !== rsp_ref(OP_SUB, a0, b0)) begin
      n_fail++;
      $display("FAIL rstmid_first: grant=%b valid=%b result=%h, expected grant=01 valid=01 result=%h",
               gnt, rv, rsp[63:0], alu_ref(OP_SUB, a0, b0));
    end
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic [1:0]  eg;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    int          lat;
    logic [68:0] rsp;
    logic [68:0] exp;
    logic [2:0]  op0;
    logic [2:0]  op1;
    logic [63:0] a0;
    logic [63:0] b0;
    logic [63:0] a1;
    logic [63:0] b1;
    for (int t = 0; t < 40; t++) begin
      v   = 2'($urandom_range(1, 3));
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      a0  = rnd64(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd64();
      a1  = rnd64(); b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd64();
      eg  = exp_grant(v);
      exp = (eg == 2'b10) ? rsp_ref(op1, a1, b1) : rsp_ref(op0, a0, b0);
      run_op(v, op0, a0, b0, op1, a1, b1, gnt, lat, rv, rsp);
      m_last = (eg == 2'b10);
      if (eg == 2'b10) m_g1++; else m_g0++;
      if (exp[68]) m_err++;
      n_checks++;
      if (gnt !== eg || lat != 2 || rv !== eg) begin
        n_fail++;
        $display("FAIL rand%0d_handshake: grant=%b latency=%0d valid=%b, expected grant=%b latency=2 valid=%b",
                 t, gnt, lat, rv, eg, eg);
      end
      n_checks++;
      if (rsp !== exp) begin
        n_fail++;
        $display("FAIL rand%0d_rsp: err=%b flags=%b result=%h, expected err=%b flags=%b result=%h",
                 t, rsp[68], rsp[67:64], rsp[63:0], exp[68], exp[67:64], exp[63:0]);
      end
    end
`ifdef ALU_SCHED_STATS_EN
    n_checks++;
    if (grant_cnt0 !== TB_CNT_W'(sat(m_g0)) || grant_cnt1 !== TB_CNT_W'(sat(m_g1)) ||
        err_cnt !== TB_CNT_W'(sat(m_err))) begin
      n_fail++;
      $display("FAIL rand_stats: g0=%0d g1=%0d err=%0d, expected %0d %0d %0d",
               grant_cnt0, grant_cnt1, err_cnt, sat(m_g0), sat(m_g1), sat(m_err));
    end
`endif
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.rsp_ready  = 2'b00;
    bus.req_a0     = '0; bus.req_b0 = '0; bus.req_cntrl0 = OP_PASSB;
    bus.req_a1     = '0; bus.req_b1 = '0; bus.req_cntrl1 = OP_PASSB;
    #1 reset_n = 1'b0;
    test_reset();
    test_single_add();
    test_illegal();
    test_contention();
    test_backpressure();
    test_stats();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
